hetszegmens_scan: RTL

//  Parametrised multiplexed 7-segment driver for DIGITS common-anode digits.
//  - Full hex decode; per-digit decimal point and blanking; optional leading-zero suppression.
//  - Anti-ghosting dead time at every digit switch; PWM brightness control.
//  - Frame-coherent input snapshot.

---
 rtl/hetszegmens_scan.sv | 112 +++++++++++
 1 files changed

// File: rtl/hetszegmens_scan.sv
// hetszegmens_scan: multiplexed common-anode 7-segment driver with dead time, PWM and frame snapshot
// Outputs are registered copies of the decode of the previous cycle's scan state.
module hetszegmens_scan #(
   parameter int DIGITS    = 4,
   parameter int CLK_HZ    = 16_000_000,
   parameter int DIGIT_HZ  = 1_000,
   parameter int BLANK_CYC = 16,
   parameter int PWM_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  lz_en,
   input  logic [PWM_BITS-1:0]   bright,
   output logic [DIGITS-1:0]     AN,
   output logic [7:0]            SEG,
   output logic                  frame_start
);
   localparam int TICK = CLK_HZ / DIGIT_HZ;
   localparam int SW = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(TICK - 1);
   localparam logic [SW-1:0] BLANK_L = SW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] ONE = 1;
   localparam logic [127:0] DEC = {8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
                                   8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};

   if (DIGITS < 1 || DIGITS > 8 || TICK <= BLANK_CYC + 2**PWM_BITS) begin : g_bad_params
      $error("hetszegmens_scan: illegal DIGITS or slot too short for blank plus PWM period");
   end

   logic [SW-1:0]       slot_q, slot_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [4*DIGITS-1:0] din_s_q, din_s_d;
   logic [DIGITS-1:0]   dp_s_q, dp_s_d, blank_s_q, blank_s_d;
   logic                lz_s_q, lz_s_d;
   logic [PWM_BITS-1:0] bright_s_q, bright_s_d;
   logic                load_pending_q, load_pending_d;
   logic                frame_start_q, frame_start_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                wrap, active, load, lit, hi_zero;
   logic [DIGITS-1:0]   supp;
   logic [3:0]          nib;
   logic [7:0]          dec;

   always_comb begin
      wrap = slot_q == SLOT_LAST;
      active = slot_q >= BLANK_L;
      load = load_pending_q | (wrap & (idx_q == IDX_LAST));
      slot_d = wrap ? '0 : slot_q + 1'b1;
      idx_d = wrap ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
      pwm_d = (wrap | ~active) ? '0 : pwm_q + 1'b1;
      load_pending_d = 1'b0;
      frame_start_d = load;
      din_s_d = load ? din : din_s_q;
      dp_s_d = load ? dp_in : dp_s_q;
      blank_s_d = load ? blank_in : blank_s_q;
      lz_s_d = load ? lz_en : lz_s_q;
      bright_s_d = load ? bright : bright_s_q;
      // a digit is suppressed when it and every more significant nibble are zero
      hi_zero = 1'b1;
      supp = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         hi_zero = hi_zero & (din_s_q[4*k +: 4] == 4'h0);
         supp[k] = lz_s_q & hi_zero & (k != 0);
      end
      nib = din_s_q[{idx_q, 2'b00} +: 4];
      dec = DEC[{nib, 3'b000} +: 8];
      lit = active & (pwm_q <= bright_s_q) & ~blank_s_q[idx_q];
      an_d = lit ? ~(ONE << idx_q) : '1;
      seg_d = lit ? {supp[idx_q] ? 7'h7F : dec[7:1], ~dp_s_q[idx_q]} : 8'hFF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q <= '0;
         idx_q <= '0;
         pwm_q <= '0;
         din_s_q <= '0;
         dp_s_q <= '0;
         blank_s_q <= '0;
         lz_s_q <= 1'b0;
         bright_s_q <= '0;
         load_pending_q <= 1'b1;
         frame_start_q <= 1'b0;
         an_q <= '1;
         seg_q <= 8'hFF;
      end else begin
         slot_q <= slot_d;
         idx_q <= idx_d;
         pwm_q <= pwm_d;
         din_s_q <= din_s_d;
         dp_s_q <= dp_s_d;
         blank_s_q <= blank_s_d;
         lz_s_q <= lz_s_d;
         bright_s_q <= bright_s_d;
         load_pending_q <= load_pending_d;
         frame_start_q <= frame_start_d;
         an_q <= an_d;
         seg_q <= seg_d;
      end
   end

   assign AN = an_q;
   assign SEG = seg_q;
   assign frame_start = frame_start_q;
endmodule
